param_deserializer: RTL and testbench
=====================================

PARAM_DESERIALIZER -- requirements
Module: param_deserializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, maximum frame data bits (legal 5..16).
REQ-002 SHALL have parameter MSB_FIRST, default 0: 0 = first received bit is data bit 0, 1 = first received bit is data bit DataLen-1.
REQ-003 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-005 SHALL have port SampledBit  input  1  serial data bit, valid when Enable=1.
REQ-006 SHALL have port Enable  input  1  one-cycle strobe: accept SampledBit this cycle.
REQ-007 SHALL have port Clear  input  1  synchronous frame abort.
REQ-008 SHALL have port DataLen  input  $clog2(DATA_WIDTH+1)  data bits per frame; sampled at frame start.
REQ-009 SHALL have port PReady  input  1  downstream accepts PData when PValid=1.
REQ-010 SHALL have port PData  output  DATA_WIDTH  assembled word, right-aligned, unused upper bits 0.
REQ-011 SHALL have port PValid  output  1  PData holds an unconsumed word.
REQ-012 SHALL have port Busy  output  1  frame in progress (state not IDLE).
REQ-013 SHALL have port Overrun  output  1  one-cycle pulse: completed frame dropped.

Function
REQ-014 SHALL implement FSM states IDLE, DATA, and PARITY (PARITY exists only with the parity feature).
REQ-015 IDLE + Enable: latch DataLen as FrameLen (0 or >DATA_WIDTH is replaced by DATA_WIDTH), store bit, counter=1, go DATA; if FrameLen==1, complete immediately.
REQ-016 DATA + Enable: store bit, counter+1; when counter reaches FrameLen, go PARITY if enabled, otherwise complete and return to IDLE.
REQ-017 Cycles without Enable SHALL leave state, counter, and shift register unchanged.
REQ-018 Bit placement: MSB_FIRST=0 puts the k-th received bit (k from 0) at index k; MSB_FIRST=1 puts it at index FrameLen-1-k.
REQ-019 Completion SHALL load PData and set PValid on the next edge (latency 1 cycle after the last data or parity bit) when PValid=0 or PReady=1 in the same cycle.
REQ-020 Completion with PValid=1 and PReady=0 SHALL leave PData unchanged, drop the frame, and pulse Overrun for 1 cycle.
REQ-021 PValid=1 and PReady=1 with no completion SHALL clear PValid on the next edge; PData holds its value.
REQ-022 PData and PValid SHALL NOT change while PValid=1 and PReady=0, except under reset.
REQ-023 Clear SHALL force IDLE, zero the counter and shift register, and leave PData/PValid untouched; Clear wins over a simultaneous Enable (bit discarded, no completion).
REQ-024 A DataLen change mid-frame SHALL be ignored until the next frame start.
REQ-025 Busy SHALL be 1 exactly when state is not IDLE.

Reset
REQ-026 RST=1 on a clock edge SHALL force IDLE, counter=0, shift register=0, PData=0, PValid=0, Busy=0, Overrun=0, ParErr=0.
REQ-027 RST SHALL take priority over Clear, Enable, and PReady; a frame in progress is discarded.

Configuration
REQ-028 Macro DESER_PARITY_EN defined: adds input ParTyp (0 even, 1 odd), output ParErr, and the PARITY state.
REQ-029 With DESER_PARITY_EN, PARITY + Enable SHALL take SampledBit as the parity bit and complete; ParErr loads together with PData, is 1 on mismatch over the FrameLen data bits, and clears with PValid.
REQ-030 With DESER_PARITY_EN, a parity-error frame SHALL still be delivered; dropped frames SHALL NOT update ParErr.
REQ-031 Without DESER_PARITY_EN, ParTyp, ParErr, and the PARITY state SHALL be absent; completion follows the last data bit.

Verification
REQ-032 DATA_WIDTH=8, MSB_FIRST=0, DataLen=8, bits 1,0,1,1,0,0,1,0 with Enable gapped by 15 idle cycles -> PData=0x4D, PValid=1 one cycle after the 8th bit.
REQ-033 MSB_FIRST=1, DataLen=5, bits 1,0,0,1,1 -> PData=0x13, upper bits 0.
REQ-034 Two 8-bit frames 0xA5 then 0x3C with PReady=0 -> PData stays 0xA5, Overrun pulses once at second completion; then PReady=1 -> PValid drops next edge.
REQ-035 Clear asserted with Enable on the 4th bit, followed by a full 0x81 frame -> PData=0x81, Busy=0 between frames.
REQ-036 RST asserted mid-frame after 3 bits -> all outputs 0; next 8 bits form a fresh frame.
REQ-037 DESER_PARITY_EN, ParTyp=0, data 0x07 with parity bit 0 -> PData=0x07, ParErr=1; with parity bit 1 -> ParErr=0.

Source files
------------

// File: rtl/param_deserializer.sv
`default_nettype none
// param_deserializer: assembles strobed serial bits into a right-aligned word with valid/ready output.
// Optional parity stage (ParTyp/ParErr, PARITY state) is built when DESER_PARITY_EN is defined.
module param_deserializer #(
    parameter int DATA_WIDTH = 8,
    parameter int MSB_FIRST  = 0
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic                                  SampledBit,
    input  logic                                  Enable,
    input  logic                                  Clear,
    input  logic [$clog2(DATA_WIDTH+1)-1:0]       DataLen,
    input  logic                                  PReady,
    output logic [DATA_WIDTH-1:0]                 PData,
    output logic                                  PValid,
    output logic                                  Busy,
`ifdef DESER_PARITY_EN
    input  logic                                  ParTyp,
    output logic                                  ParErr,
`endif
    output logic                                  Overrun
);

    localparam int LW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
`ifdef DESER_PARITY_EN
        PARITY = 2'd2,
`endif
        DATA   = 2'd1
    } state_t;

    state_t                state, state_nx;
    logic [LW-1:0]         frame_len, frame_len_nx;
    logic [LW-1:0]         count, count_nx;
    logic [LW-1:0]         eff_len, len_cur, k, idx;
    logic [DATA_WIDTH-1:0] shreg, shreg_nx, placed, word;
    logic                  last, complete;
`ifdef DESER_PARITY_EN
    logic                  par_err_nx;
`endif

    // Out-of-range lengths (0 or wider than the datapath) fall back to the full width.
    assign eff_len = (DataLen == '0 || DataLen > LW'(DATA_WIDTH)) ? LW'(DATA_WIDTH) : DataLen;
    assign Busy    = (state != IDLE);

    always_comb begin
        state_nx     = state;
        frame_len_nx = frame_len;
        count_nx     = count;
        shreg_nx     = shreg;
        complete     = 1'b0;
        word         = shreg;
`ifdef DESER_PARITY_EN
        par_err_nx   = 1'b0;
`endif
        // At frame start the live DataLen is used, since frame_len is loaded on this same edge.
        len_cur = (state == IDLE) ? eff_len : frame_len;
        k       = (state == IDLE) ? '0 : count;
        idx     = (MSB_FIRST != 0) ? (len_cur - LW'(1) - k) : k;
        placed  = ((state == IDLE) ? '0 : shreg) | (DATA_WIDTH'(SampledBit) << idx);
        last    = ((k + LW'(1)) == len_cur);

        if (Clear) begin
            state_nx = IDLE;
            count_nx = '0;
            shreg_nx = '0;
        end else if (Enable) begin
            case (state)
                IDLE, DATA: begin
                    if (state == IDLE) begin
                        frame_len_nx = eff_len;
                    end
                    shreg_nx = placed;
                    count_nx = k + LW'(1);
                    state_nx = DATA;
                    if (last) begin
`ifdef DESER_PARITY_EN
                        state_nx = PARITY;
`else
                        complete = 1'b1;
                        word     = placed;
                        state_nx = IDLE;
                        count_nx = '0;
                        shreg_nx = '0;
`endif
                    end
                end
`ifdef DESER_PARITY_EN
                PARITY: begin
                    complete   = 1'b1;
                    word       = shreg;
                    par_err_nx = SampledBit ^ ParTyp ^ (^shreg);
                    state_nx   = IDLE;
                    count_nx   = '0;
                    shreg_nx   = '0;
                end
`endif
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            frame_len <= '0;
            count     <= '0;
            shreg     <= '0;
            PData     <= '0;
            PValid    <= 1'b0;
            Overrun   <= 1'b0;
`ifdef DESER_PARITY_EN
            ParErr    <= 1'b0;
`endif
        end else begin
            state     <= state_nx;
            frame_len <= frame_len_nx;
            count     <= count_nx;
            shreg     <= shreg_nx;
            Overrun   <= 1'b0;
            if (complete) begin
                if (!PValid || PReady) begin
                    PData  <= word;
                    PValid <= 1'b1;
`ifdef DESER_PARITY_EN
                    ParErr <= par_err_nx;
`endif
                end else begin
                    Overrun <= 1'b1;
                end
            end else if (PValid && PReady) begin
                PValid <= 1'b0;
`ifdef DESER_PARITY_EN
                ParErr <= 1'b0;
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_param_deserializer.sv
`default_nettype none
// tb_param_deserializer: directed scoreboard bench for LSB-first (a) and MSB-first (b) instances.
module tb_param_deserializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sbit = 1'b0;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic       pready = 1'b0;
    logic [3:0] dlen = 4'd8;
    logic [7:0] pdata_a, pdata_b;
    logic       pvalid_a, pvalid_b, busy_a, busy_b, ovr_a, ovr_b;
`ifdef DESER_PARITY_EN
    logic       ptyp = 1'b0;
    logic       perr_a, perr_b;
`endif

    int total = 0;
    int bad   = 0;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    always #5 clk = ~clk;

    param_deserializer #(.DATA_WIDTH(8), .MSB_FIRST(0)) dut_a (
        .CLK(clk), .RST(rst), .SampledBit(sbit), .Enable(en), .Clear(clr),
        .DataLen(dlen), .PReady(pready), .PData(pdata_a), .PValid(pvalid_a),
        .Busy(busy_a),
`ifdef DESER_PARITY_EN
        .ParTyp(ptyp), .ParErr(perr_a),
`endif
        .Overrun(ovr_a)
    );

    param_deserializer #(.DATA_WIDTH(8), .MSB_FIRST(1)) dut_b (
        .CLK(clk), .RST(rst), .SampledBit(sbit), .Enable(en), .Clear(clr),
        .DataLen(dlen), .PReady(pready), .PData(pdata_b), .PValid(pvalid_b),
        .Busy(busy_b),
`ifdef DESER_PARITY_EN
        .ParTyp(ptyp), .ParErr(perr_b),
`endif
        .Overrun(ovr_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bit_in(input logic b);
        sbit = b;
        en   = 1'b1;
        tick();
        en   = 1'b0;
        sbit = 1'b0;
    endtask

    function automatic logic [7:0] rev(input logic [7:0] w, input int len);
        logic [7:0] r = '0;
        for (int i = 0; i < len; i++) r[len-1-i] = w[i];
        return r;
    endfunction

    // Sends w[0] first; with parity built, appends a parity bit (inverted when flip=1).
    task automatic frame(input logic [7:0] w, input logic [3:0] dl, input int len,
                         input int gap, input logic flip, input logic drop);
        if (!drop) begin
            q_a.push_back(w);
            q_b.push_back(rev(w, len));
        end
        dlen = dl;
        for (int i = 0; i < len; i++) begin
            bit_in(w[i]);
`ifdef DESER_PARITY_EN
            repeat (gap) tick();
`else
            if (i < len - 1) repeat (gap) tick();
`endif
        end
`ifdef DESER_PARITY_EN
        bit_in((^w) ^ ptyp ^ flip);
`else
        if (flip) chk("flip_unused", 32'(flip), 32'd0);
`endif
        dlen = 4'd8;
    endtask

    task automatic check_out(input string tag);
        chk({tag, "_pvalid_a"}, 32'(pvalid_a), 32'd1);
        chk({tag, "_pvalid_b"}, 32'(pvalid_b), 32'd1);
        if (q_a.size() == 0 || q_b.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 32'(q_a.size() + q_b.size()), 32'd2);
        end else begin
            chk({tag, "_pdata_a"}, 32'(pdata_a), 32'(q_a.pop_front()));
            chk({tag, "_pdata_b"}, 32'(pdata_b), 32'(q_b.pop_front()));
        end
    endtask

    task automatic consume(input string tag);
        logic [7:0] held;
        held   = pdata_a;
        pready = 1'b1;
        tick();
        pready = 1'b0;
        chk({tag, "_drop_pvalid"}, 32'(pvalid_a), 32'd0);
        chk({tag, "_hold_pdata"}, 32'(pdata_a), 32'(held));
`ifdef DESER_PARITY_EN
        chk({tag, "_perr_clear"}, 32'(perr_a), 32'd0);
`endif
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_pdata", 32'(pdata_a), 32'd0);
        chk("rst_pvalid", 32'(pvalid_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_ovr", 32'(ovr_a), 32'd0);
        rst = 1'b0;
        tick();

        // Gapped 8-bit frame: bits 1,0,1,1,0,0,1,0
        bit_in(1'b1);
        chk("busy_after_first", 32'(busy_a), 32'd1);
        repeat (15) tick();
        chk("busy_in_gap", 32'(busy_a), 32'd1);
        chk("no_valid_midframe", 32'(pvalid_a), 32'd0);
        q_a.push_back(8'h4D);
        q_b.push_back(8'hB2);
        for (int i = 1; i < 8; i++) begin
            bit_in(8'h4D >> i & 8'h01 ? 1'b1 : 1'b0);
`ifdef DESER_PARITY_EN
            repeat (15) tick();
`else
            if (i < 7) repeat (15) tick();
`endif
        end
`ifdef DESER_PARITY_EN
        bit_in(^(8'h4D) ^ ptyp);
`endif
        check_out("f4d");
        chk("f4d_busy_done", 32'(busy_a), 32'd0);
        consume("f4d");

        // 5-bit frame 1,0,0,1,1: LSB-first 0x19, MSB-first 0x13
        frame(8'h19, 4'd5, 5, 0, 1'b0, 1'b0);
        check_out("len5");
        consume("len5");

        // Backpressure: second frame dropped with a single Overrun pulse
        frame(8'hA5, 4'd8, 8, 0, 1'b0, 1'b0);
        check_out("a5");
        frame(8'h3C, 4'd8, 8, 0, 1'b0, 1'b1);
        chk("ovr_pulse_a", 32'(ovr_a), 32'd1);
        chk("ovr_pulse_b", 32'(ovr_b), 32'd1);
        chk("ovr_keep_pdata", 32'(pdata_a), 32'hA5);
        chk("ovr_keep_pvalid", 32'(pvalid_a), 32'd1);
        tick();
        chk("ovr_one_cycle", 32'(ovr_a), 32'd0);
        repeat (3) tick();
        chk("stall_pdata", 32'(pdata_a), 32'hA5);
        chk("stall_pvalid", 32'(pvalid_a), 32'd1);
        consume("a5");

        // Clear together with the 4th bit, then a full 0x81 frame
        bit_in(1'b1);
        bit_in(1'b1);
        bit_in(1'b0);
        sbit = 1'b1;
        en   = 1'b1;
        clr  = 1'b1;
        tick();
        en   = 1'b0;
        clr  = 1'b0;
        chk("clr_busy", 32'(busy_a), 32'd0);
        chk("clr_no_valid", 32'(pvalid_a), 32'd0);
        frame(8'h81, 4'd8, 8, 0, 1'b0, 1'b0);
        check_out("f81");
        consume("f81");

        // Reset mid-frame after 3 bits, then a fresh frame
        bit_in(1'b1);
        bit_in(1'b0);
        bit_in(1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_pdata", 32'(pdata_a), 32'd0);
        chk("midrst_busy", 32'(busy_a), 32'd0);
        chk("midrst_pvalid", 32'(pvalid_a), 32'd0);
        frame(8'h5A, 4'd8, 8, 0, 1'b0, 1'b0);
        check_out("f5a");
        consume("f5a");

        // DataLen 0 and 15 both mean full width; DataLen 1 completes on the first bit
        frame(8'h3C, 4'd0, 8, 0, 1'b0, 1'b0);
        check_out("len0");
        consume("len0");
        frame(8'hC3, 4'd15, 8, 1, 1'b0, 1'b0);
        check_out("len15");
        consume("len15");
        frame(8'h01, 4'd1, 1, 0, 1'b0, 1'b0);
        check_out("len1");
        chk("len1_busy", 32'(busy_a), 32'd0);
        consume("len1");

        // DataLen change mid-frame is ignored: length stays 4
        q_a.push_back(8'h0D);
        q_b.push_back(8'h0B);
        dlen = 4'd4;
        bit_in(1'b1);
        dlen = 4'd8;
        bit_in(1'b0);
        bit_in(1'b1);
        bit_in(1'b1);
`ifdef DESER_PARITY_EN
        bit_in(^(4'hD) ^ ptyp);
`endif
        check_out("dlen_chg");
        consume("dlen_chg");

`ifdef DESER_PARITY_EN
        ptyp = 1'b0;
        frame(8'h07, 4'd8, 8, 0, 1'b1, 1'b0);
        check_out("par_bad");
        chk("par_bad_err", 32'(perr_a), 32'd1);
        consume("par_bad");
        frame(8'h07, 4'd8, 8, 0, 1'b0, 1'b0);
        check_out("par_ok");
        chk("par_ok_err", 32'(perr_a), 32'd0);
        consume("par_ok");
        ptyp = 1'b1;
        frame(8'h07, 4'd8, 8, 0, 1'b0, 1'b0);
        check_out("par_odd");
        chk("par_odd_err", 32'(perr_b), 32'd0);
        consume("par_odd");
`endif

        chk("scoreboard_drained", 32'(q_a.size() + q_b.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
